dot_chunk_sched: RTL and testbench

//  Sequences long dot products (length chunks*N) through the pipelined naive_dot core.

---
 rtl/dot_sched_pkg.sv | 43 ++++
 rtl/dot_chunk_acc.sv | 42 ++++
 rtl/dot_chunk_sched.sv | 135 +++++++++++++
 tb/tb_dot_chunk_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_sched_pkg.sv
// Shared types and arithmetic helpers for the chunked dot-product scheduler.
// Holds the FSM state encoding, the chunk-counter width and the accumulation helpers.
package dot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    localparam int DEFAULT_MAX_CHUNKS = 16;

    function automatic int cnt_width(input int max_chunks);
        return $clog2(max_chunks + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_MAX_CHUNKS);

    function automatic logic signed [63:0] sext16(input logic signed [15:0] v);
        return 64'(v);
    endfunction

    // Clamp a+b to the signed range representable in 'width' bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dot_chunk_acc.sv
// Job accumulator: clear on job accept, add each sign-extended core result.
// Define DOT_SCHED_SAT_EN for saturating accumulation; otherwise it wraps at ACC_WIDTH.
module dot_chunk_acc
    import dot_sched_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        add,
    input  logic signed [15:0]          add_value,
    output logic signed [ACC_WIDTH-1:0] result
);

    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (clear) begin
            acc_next = '0;
        end else if (add) begin
`ifdef DOT_SCHED_SAT_EN
            acc_next = ACC_WIDTH'(sat_add(64'(acc_reg), sext16(add_value), ACC_WIDTH));
`else
            acc_next = acc_reg + ACC_WIDTH'(sext16(add_value));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign result = acc_reg;

endmodule

// File: rtl/dot_chunk_sched.sv
// Streams operand chunks of a long dot product into the naive_dot core and sums the results.
// Build option DOT_SCHED_SAT_EN (in dot_chunk_acc) selects saturating accumulation.
module dot_chunk_sched
    import dot_sched_pkg::*;
#(
    parameter int N            = 128,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACT_WIDTH    = 4,
    parameter int MAX_CHUNKS   = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int CORE_LAT     = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [cnt_width(MAX_CHUNKS)-1:0]   cmd_chunks,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [N*WEIGHT_WIDTH-1:0]          op_weights_flat,
    input  logic [N*ACT_WIDTH-1:0]             op_acts_flat,
    output logic                               core_start,
    output logic [N*WEIGHT_WIDTH-1:0]          core_weights_flat,
    output logic [N*ACT_WIDTH-1:0]             core_acts_flat,
    input  logic                               core_done,
    input  logic signed [15:0]                 core_result,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic signed [ACC_WIDTH-1:0]        res_data,
    output logic                               busy
);

    localparam int CW = cnt_width(MAX_CHUNKS);

    generate
        if (ACC_WIDTH < 16 || CORE_LAT < 1) begin : g_param_check
            $error("dot_chunk_sched: ACC_WIDTH must be >= 16 and CORE_LAT >= 1");
        end
    endgenerate

    state_t              state_reg;
    state_t              state_next;
    logic [CW-1:0]       n_reg;
    logic [CW-1:0]       issue_cnt_reg;
    logic [CW-1:0]       done_cnt_reg;
    logic [CW-1:0]       n_clamped;
    logic                core_start_reg;
    logic [N*WEIGHT_WIDTH-1:0] weights_reg;
    logic [N*ACT_WIDTH-1:0]    acts_reg;
    logic                cmd_fire;
    logic                op_fire;
    logic                done_take;

    assign cmd_ready = (state_reg == IDLE);
    assign op_ready  = (state_reg == ISSUE);
    assign res_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign op_fire   = op_valid & op_ready;
    // Results only count while a job has chunks in flight; stray dones are dropped.
    assign done_take = core_done & ((state_reg == ISSUE) | (state_reg == DRAIN));
    assign n_clamped = (cmd_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : cmd_chunks;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = (n_clamped == '0) ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                if (op_fire && (issue_cnt_reg + CW'(1) == n_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (done_take && (done_cnt_reg + CW'(1) == n_reg)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            n_reg          <= '0;
            issue_cnt_reg  <= '0;
            done_cnt_reg   <= '0;
            core_start_reg <= 1'b0;
            weights_reg    <= '0;
            acts_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            core_start_reg <= op_fire;
            if (op_fire) begin
                weights_reg   <= op_weights_flat;
                acts_reg      <= op_acts_flat;
                issue_cnt_reg <= issue_cnt_reg + CW'(1);
            end
            if (done_take) begin
                done_cnt_reg <= done_cnt_reg + CW'(1);
            end
            if (cmd_fire) begin
                n_reg         <= n_clamped;
                issue_cnt_reg <= '0;
                done_cnt_reg  <= '0;
            end
        end
    end

    assign core_start        = core_start_reg;
    assign core_weights_flat = weights_reg;
    assign core_acts_flat    = acts_reg;

    dot_chunk_acc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (cmd_fire),
        .add       (done_take),
        .add_value (core_result),
        .result    (res_data)
    );

endmodule

// File: tb/tb_dot_chunk_sched.sv
// Randomized bench for dot_chunk_sched with a latency-accurate core stand-in and a sum model.
// A second instance with a 16-bit accumulator exercises wrap (or DOT_SCHED_SAT_EN saturation).
module tb_dot_chunk_sched;
    import dot_sched_pkg::*;

    localparam int N    = 128;
    localparam int WW   = 4;
    localparam int AW   = 4;
    localparam int MAXC = 16;
    localparam int ACCW = 24;
    localparam int LAT  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 cmd_valid = 1'b0;
    logic [CNT_W-1:0]     cmd_chunks = '0;
    logic                 op_valid = 1'b0;
    logic [N*WW-1:0]      op_weights_flat = '0;
    logic [N*AW-1:0]      op_acts_flat = '0;
    logic                 res_ready = 1'b0;
    logic                 core_done;
    logic signed [15:0]   core_result;

    logic                 cmd_ready, op_ready, core_start, res_valid, busy;
    logic [N*WW-1:0]      core_weights_flat;
    logic [N*AW-1:0]      core_acts_flat;
    logic signed [ACCW-1:0] res_data;

    logic                 cmd_ready2, op_ready2, core_start2, res_valid2, busy2;
    logic [N*WW-1:0]      core_weights_flat2;
    logic [N*AW-1:0]      core_acts_flat2;
    logic signed [15:0]   res_data2;

    dot_chunk_sched #(.N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .MAX_CHUNKS(MAXC),
                      .ACC_WIDTH(ACCW), .CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chunks(cmd_chunks), .op_valid(op_valid), .op_ready(op_ready),
        .op_weights_flat(op_weights_flat), .op_acts_flat(op_acts_flat),
        .core_start(core_start), .core_weights_flat(core_weights_flat),
        .core_acts_flat(core_acts_flat), .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    dot_chunk_sched #(.N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .MAX_CHUNKS(MAXC),
                      .ACC_WIDTH(16), .CORE_LAT(LAT)) dut16 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_chunks(cmd_chunks), .op_valid(op_valid), .op_ready(op_ready2),
        .op_weights_flat(op_weights_flat), .op_acts_flat(op_acts_flat),
        .core_start(core_start2), .core_weights_flat(core_weights_flat2),
        .core_acts_flat(core_acts_flat2), .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2), .busy(busy2)
    );

    // Core stand-in: result of the operands present at start, done LAT cycles later.
    function automatic logic signed [15:0] core_dot(input logic [N*WW-1:0] wf,
                                                    input logic [N*AW-1:0] af);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            s += int'($signed(wf[i*WW +: WW])) * int'($signed(af[i*AW +: AW]));
        end
        return 16'(s);
    endfunction

    logic [LAT-1:0]     done_pipe;
    logic signed [15:0] res_pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            done_pipe <= '0;
            for (int k = 0; k < LAT; k++) res_pipe[k] <= '0;
        end else begin
            done_pipe   <= {done_pipe[LAT-2:0], core_start};
            res_pipe[0] <= core_dot(core_weights_flat, core_acts_flat);
            for (int k = 1; k < LAT; k++) res_pipe[k] <= res_pipe[k-1];
        end
    end
    assign core_done   = done_pipe[LAT-1];
    assign core_result = res_pipe[LAT-1];

    int errors = 0;
    int checks = 0;
    int w_mem [MAXC][N];
    int a_mem [MAXC][N];

    task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
        checks++;
        if (got !== 64'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap_w(input longint x, input int w);
        longint m = longint'(1) << w;
        longint y = x % m;
        if (y < 0) y += m;
        if (y >= m / 2) y -= m;
        return y;
    endfunction

    function automatic longint sat_w(input longint x, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        if (x > hi) return hi;
        if (x < -hi - 1) return -hi - 1;
        return x;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "/cmd_ready"}, 64'(cmd_ready), 1);
        check({tag, "/op_ready"},  64'(op_ready), 0);
        check({tag, "/core_start"}, 64'(core_start), 0);
        check({tag, "/core_w"},    64'(|core_weights_flat), 0);
        check({tag, "/core_a"},    64'(|core_acts_flat), 0);
        check({tag, "/res_valid"}, 64'(res_valid), 0);
        check({tag, "/res_data"},  64'(res_data), 0);
        check({tag, "/busy"},      64'(busy), 0);
        check({tag, "/dut16_idle"},
              64'({cmd_ready2, op_ready2, core_start2, res_valid2, busy2}), 64'(5'b10000));
        check({tag, "/dut16_regs"},
              64'((|core_weights_flat2) | (|core_acts_flat2) | (|res_data2)), 0);
    endtask

    // mode: 0 all ones, 1 all -8, 2 random. abort_after>=0 pulses rst once that many chunks went in.
    task automatic run_job(input string tag, input int nreq, input int mode, input int gap_pct,
                           input int stall, input int abort_after);
        int eff, sent, cmd_cyc, first_op_cyc, res_cyc, stall_left, starts;
        bit accepted, cmd_fire_q, op_fire_q, res_fire_q, finished, unstable, seen_res, v16;
        longint exp_full, exp16, dot;
        logic [ACCW-1:0] held;
        logic [15:0]     held16;
        eff = (nreq > MAXC) ? MAXC : nreq;
        exp_full = 0;
        exp16 = 0;
        for (int c = 0; c < eff; c++) begin
            dot = 0;
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0: begin w_mem[c][i] = 1;  a_mem[c][i] = 1;  end
                    1: begin w_mem[c][i] = -8; a_mem[c][i] = -8; end
                    default: begin
                        w_mem[c][i] = int'($urandom_range(15)) - 8;
                        a_mem[c][i] = int'($urandom_range(15)) - 8;
                    end
                endcase
                dot += longint'(w_mem[c][i] * a_mem[c][i]);
            end
            exp_full += dot;
`ifdef DOT_SCHED_SAT_EN
            exp16 = sat_w(exp16 + dot, 16);
`else
            exp16 = wrap_w(exp16 + dot, 16);
`endif
        end
        sent = 0; cmd_cyc = 0; first_op_cyc = 0; res_cyc = 0; stall_left = 0; starts = 0;
        accepted = 0; cmd_fire_q = 0; op_fire_q = 0; res_fire_q = 0;
        finished = 0; unstable = 0; seen_res = 0; v16 = 0;
        held = '0; held16 = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cmd_fire_q) begin accepted = 1; cmd_cyc = cyc - 1; end
            if (op_fire_q) begin
                if (sent == 0) first_op_cyc = cyc - 1;
                sent++;
            end
            if (res_fire_q) begin finished = 1; break; end
            if (abort_after >= 0 && sent == abort_after) begin
                rst = 1'b1; cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset({tag, "/abort"});
                $display("job %s aborted after %0d chunks", tag, sent);
                return;
            end
            if (core_start) starts++;
            cmd_valid  = !accepted;
            cmd_chunks = CNT_W'(nreq);
            if (accepted && sent < eff) begin
                op_valid = ($urandom_range(99) >= gap_pct);
                for (int i = 0; i < N; i++) begin
                    op_weights_flat[i*WW +: WW] = WW'(w_mem[sent][i]);
                    op_acts_flat[i*AW +: AW]    = AW'(a_mem[sent][i]);
                end
            end else begin
                op_valid = 1'b0;
            end
            res_ready = 1'b0;
            if (res_valid) begin
                if (!seen_res) begin
                    seen_res = 1; res_cyc = cyc; held = res_data; held16 = res_data2;
                    v16 = res_valid2; stall_left = stall;
                end else if (res_data !== held || res_data2 !== held16) begin
                    unstable = 1;
                end
                if (stall_left > 0) stall_left--;
                else res_ready = 1'b1;
            end
            cmd_fire_q = cmd_valid & cmd_ready;
            op_fire_q  = op_valid & op_ready;
            res_fire_q = res_valid & res_ready;
        end
        cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        if (!finished) begin
            check({tag, "/timeout"}, 0, 1);
            return;
        end
        check({tag, "/sum"}, 64'($signed(held)), wrap_w(exp_full, ACCW));
        check({tag, "/sum16"}, 64'($signed(held16)), exp16);
        check({tag, "/valid16"}, 64'(v16), 1);
        check({tag, "/starts"}, 64'(starts), eff);
        check({tag, "/stable"}, 64'(unstable), 0);
        if (eff == 0) check({tag, "/lat0"}, 64'(res_cyc), cmd_cyc + 1);
        else if (gap_pct == 0) check({tag, "/lat"}, 64'(res_cyc), first_op_cyc + eff + 6);
        check({tag, "/post"}, 64'({cmd_ready, busy, res_valid}), 64'(3'b100));
        $display("job %s chunks=%0d sum=%0d sum16=%0d", tag, eff,
                 $signed(held), $signed(held16));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        run_job("ones4", 4, 0, 0, 0, -1);
        run_job("neg8x16", 16, 1, 0, 0, -1);
        run_job("zero", 0, 0, 0, 0, -1);
        run_job("clamp20", 20, 2, 0, 0, -1);
        run_job("one", 1, 2, 0, 0, -1);
        for (int k = 0; k < 4; k++) begin
            run_job("rand_gap", int'($urandom_range(1, 16)), 2, 40, 10, -1);
        end
        run_job("abort", 8, 2, 0, 0, 3);
        run_job("after", 2, 0, 0, 0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
